// File: rtl/control_sequencer.sv
// ============================================================================
// control_sequencer : fetch/execute T-state sequencer for the 8-bit computer
// Rev 1.0
// ============================================================================
`default_nettype none

module control_sequencer #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [DATA_W-1:0] ir_in,
  input  logic              zero_flag,
  input  logic              carry_flag,
  output logic              pc_en,
  output logic              pc_load,
  output logic              pc_down,
  output logic              addr_sel,
  output logic              mar_load,
  output logic              mem_rd,
  output logic              ir_load,
  output logic              a_load,
  output logic              b_load,
  output logic              alu_sub,
  output logic              out_load,
  output logic              halted,
  output logic [2:0]        tstate
);

  localparam logic [2:0] ST_T0   = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_T4   = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd5;

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'h3);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'h4);
  localparam logic [OP_W-1:0] OP_JMP = OP_W'(4'h5);
  localparam logic [OP_W-1:0] OP_JZ  = OP_W'(4'h6);
  localparam logic [OP_W-1:0] OP_JC  = OP_W'(4'h7);
  localparam logic [OP_W-1:0] OP_DIR = OP_W'(4'h8);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'hF);

  logic [2:0]      state_q, state_d;
  logic            pc_down_q, pc_down_d;
  logic [OP_W-1:0] w_opcode;
  logic            w_unused_operand;

  assign w_opcode         = ir_in[DATA_W-1 -: OP_W];
  // Only operand bit 0 (DIR) is consumed here; the rest feeds the PC/MAR directly.
  assign w_unused_operand = ^ir_in[DATA_W-OP_W-1:1];

  always_comb begin
    state_d   = state_q;
    pc_down_d = pc_down_q;
    pc_en     = 1'b0;
    pc_load   = 1'b0;
    addr_sel  = 1'b0;
    mar_load  = 1'b0;
    mem_rd    = 1'b0;
    ir_load   = 1'b0;
    a_load    = 1'b0;
    b_load    = 1'b0;
    alu_sub   = 1'b0;
    out_load  = 1'b0;

    case (state_q)
      ST_T0: begin
        if (run) begin
          mar_load = 1'b1;
          state_d  = ST_T1;
        end
      end

      ST_T1: begin
        if (run) begin
          mem_rd  = 1'b1;
          ir_load = 1'b1;
          pc_en   = 1'b1;
          state_d = ST_T2;
        end
      end

      ST_T2: begin
        if (run) begin
          state_d = ST_T0;
          case (w_opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              mar_load = 1'b1;
              addr_sel = 1'b1;
              state_d  = ST_T3;
            end
            OP_OUT: out_load = 1'b1;
            OP_JMP: pc_load  = 1'b1;
            OP_JZ:  pc_load  = zero_flag;
            OP_JC:  pc_load  = carry_flag;
            OP_DIR: pc_down_d = ir_in[0];
            OP_HLT: state_d  = ST_HALT;
            default: state_d = ST_T0;
          endcase
        end
      end

      ST_T3: begin
        if (run) begin
          state_d = ST_T0;
          case (w_opcode)
            OP_LDA: begin
              mem_rd = 1'b1;
              a_load = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              mem_rd  = 1'b1;
              b_load  = 1'b1;
              state_d = ST_T4;
            end
            default: state_d = ST_T0;
          endcase
        end
      end

      ST_T4: begin
        if (run) begin
          state_d = ST_T0;
          if (w_opcode == OP_ADD || w_opcode == OP_SUB) begin
            a_load  = 1'b1;
            alu_sub = (w_opcode == OP_SUB);
          end
        end
      end

      ST_HALT: state_d = ST_HALT;

      // Codes 6/7 recover to T0 regardless of run.
      default: state_d = ST_T0;
    endcase

    // Strobes must drop the moment reset asserts, not at the next edge.
    if (!rst) begin
      pc_en    = 1'b0;
      pc_load  = 1'b0;
      addr_sel = 1'b0;
      mar_load = 1'b0;
      mem_rd   = 1'b0;
      ir_load  = 1'b0;
      a_load   = 1'b0;
      b_load   = 1'b0;
      alu_sub  = 1'b0;
      out_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_T0;
      pc_down_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_down_q <= pc_down_d;
    end
  end

  assign pc_down = pc_down_q;
  assign tstate  = state_q;
  assign halted  = (state_q == ST_HALT);

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
`default_nettype none

module tb_control_sequencer;

  logic       clk;
  logic       rst;
  logic       run;
  logic [7:0] ir_in;
  logic       zero_flag;
  logic       carry_flag;
  logic       pc_en, pc_load, pc_down, addr_sel, mar_load, mem_rd;
  logic       ir_load, a_load, b_load, alu_sub, out_load, halted;
  logic [2:0] tstate;
  logic [9:0] strobes;

  int total = 0;
  int bad   = 0;

  // {pc_en,pc_load,addr_sel,mar_load,mem_rd,ir_load,a_load,b_load,alu_sub,out_load}
  localparam logic [9:0] S_NONE  = 10'b0000000000;
  localparam logic [9:0] S_FET0  = 10'b0001000000;
  localparam logic [9:0] S_FET1  = 10'b1000110000;
  localparam logic [9:0] S_ADDR2 = 10'b0011000000;
  localparam logic [9:0] S_LDB3  = 10'b0000100100;
  localparam logic [9:0] S_LDA3  = 10'b0000101000;
  localparam logic [9:0] S_ADD4  = 10'b0000001000;
  localparam logic [9:0] S_SUB4  = 10'b0000001010;
  localparam logic [9:0] S_PCLD  = 10'b0100000000;

  control_sequencer #(.DATA_W(8), .OP_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .ir_in      (ir_in),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .pc_en      (pc_en),
    .pc_load    (pc_load),
    .pc_down    (pc_down),
    .addr_sel   (addr_sel),
    .mar_load   (mar_load),
    .mem_rd     (mem_rd),
    .ir_load    (ir_load),
    .a_load     (a_load),
    .b_load     (b_load),
    .alu_sub    (alu_sub),
    .out_load   (out_load),
    .halted     (halted),
    .tstate     (tstate)
  );

  assign strobes = {pc_en, pc_load, addr_sel, mar_load, mem_rd,
                    ir_load, a_load, b_load, alu_sub, out_load};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b1; ir_in = 8'h2A; zero_flag = 1'b0; carry_flag = 1'b0;
    repeat (3) step();
    total++; if (tstate !== 3'd0) begin bad++; $display("FAIL reset_tstate: got %0d want 0", tstate); end
    total++; if (strobes !== S_NONE) begin bad++; $display("FAIL reset_strobes: got %b want %b", strobes, S_NONE); end
    total++; if (pc_down !== 1'b0) begin bad++; $display("FAIL reset_pc_down: got %b want 0", pc_down); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
    rst = 1'b1;
    #1;
    total++; if (strobes !== S_FET0) begin bad++; $display("FAIL reset_release_t0: got %b want %b", strobes, S_FET0); end
  endtask

  task automatic test_add_sub();
    logic [7:0] ops [2];
    logic [9:0] exp [5];
    ops[0] = 8'h2A; ops[1] = 8'h3A;
    for (int i = 0; i < 2; i++) begin
      ir_in  = ops[i];
      exp[0] = S_FET0; exp[1] = S_FET1; exp[2] = S_ADDR2; exp[3] = S_LDB3;
      exp[4] = (i == 0) ? S_ADD4 : S_SUB4;
      for (int k = 0; k < 5; k++) begin
        total++; if (tstate !== 3'(k)) begin bad++; $display("FAIL addsub_tstate op=%h k=%0d: got %0d want %0d", ops[i], k, tstate, k); end
        total++; if (strobes !== exp[k]) begin bad++; $display("FAIL addsub_strobes op=%h k=%0d: got %b want %b", ops[i], k, strobes, exp[k]); end
        step();
      end
      total++; if (tstate !== 3'd0) begin bad++; $display("FAIL addsub_return op=%h: got %0d want 0", ops[i], tstate); end
    end
  endtask

  task automatic test_jump();
    logic [7:0] ops [3];
    logic       zv  [3];
    logic       cv  [3];
    logic [9:0] exp [3];
    ops[0] = 8'h6C; zv[0] = 1'b1; cv[0] = 1'b0; exp[0] = S_PCLD;
    ops[1] = 8'h6C; zv[1] = 1'b0; cv[1] = 1'b1; exp[1] = S_NONE;
    ops[2] = 8'h7C; zv[2] = 1'b0; cv[2] = 1'b1; exp[2] = S_PCLD;
    for (int i = 0; i < 3; i++) begin
      ir_in = ops[i]; zero_flag = zv[i]; carry_flag = cv[i];
      step(); step();
      total++; if (tstate !== 3'd2) begin bad++; $display("FAIL jump_t2 case=%0d: got %0d want 2", i, tstate); end
      total++; if (strobes !== exp[i]) begin bad++; $display("FAIL jump_pc_load case=%0d: got %b want %b", i, strobes, exp[i]); end
      step();
      total++; if (tstate !== 3'd0) begin bad++; $display("FAIL jump_return case=%0d: got %0d want 0", i, tstate); end
    end
    zero_flag = 1'b0; carry_flag = 1'b0;
  endtask

  task automatic test_dir();
    ir_in = 8'h81;
    step(); step();
    total++; if (pc_down !== 1'b0) begin bad++; $display("FAIL dir_before_edge: got %b want 0", pc_down); end
    step();
    total++; if (pc_down !== 1'b1) begin bad++; $display("FAIL dir_set: got %b want 1", pc_down); end
    total++; if (tstate !== 3'd0) begin bad++; $display("FAIL dir_return: got %0d want 0", tstate); end
    ir_in = 8'h00;
    step(); step(); step();
    total++; if (pc_down !== 1'b1) begin bad++; $display("FAIL dir_persist: got %b want 1", pc_down); end
    ir_in = 8'h80;
    step(); step(); step();
    total++; if (pc_down !== 1'b0) begin bad++; $display("FAIL dir_clear: got %b want 0", pc_down); end
  endtask

  task automatic test_freeze();
    ir_in = 8'h1A;
    step(); step(); step();
    total++; if (tstate !== 3'd3) begin bad++; $display("FAIL freeze_reach_t3: got %0d want 3", tstate); end
    run = 1'b0;
    #1;
    total++; if (strobes !== S_NONE) begin bad++; $display("FAIL freeze_gate: got %b want %b", strobes, S_NONE); end
    for (int k = 0; k < 4; k++) begin
      step();
      total++; if (tstate !== 3'd3 || strobes !== S_NONE) begin bad++; $display("FAIL freeze_hold k=%0d: got t=%0d s=%b want t=3 s=%b", k, tstate, strobes, S_NONE); end
    end
    run = 1'b1;
    #1;
    total++; if (strobes !== S_LDA3) begin bad++; $display("FAIL freeze_resume: got %b want %b", strobes, S_LDA3); end
    step();
    total++; if (tstate !== 3'd0) begin bad++; $display("FAIL freeze_return: got %0d want 0", tstate); end
  endtask

  task automatic test_halt();
    ir_in = 8'hF0;
    step(); step();
    total++; if (strobes !== S_NONE) begin bad++; $display("FAIL halt_t2_strobes: got %b want %b", strobes, S_NONE); end
    step();
    total++; if (tstate !== 3'd5 || halted !== 1'b1) begin bad++; $display("FAIL halt_enter: got t=%0d h=%b want t=5 h=1", tstate, halted); end
    for (int k = 0; k < 10; k++) begin
      step();
      total++; if (tstate !== 3'd5 || halted !== 1'b1 || strobes !== S_NONE) begin bad++; $display("FAIL halt_hold k=%0d: got t=%0d h=%b s=%b want t=5 h=1 s=0", k, tstate, halted, strobes); end
    end
  endtask

  task automatic test_async_reset();
    #2;
    rst = 1'b0;
    #1;
    total++; if (tstate !== 3'd0 || halted !== 1'b0) begin bad++; $display("FAIL async_leave_halt: got t=%0d h=%b want t=0 h=0", tstate, halted); end
    rst = 1'b1;
    ir_in = 8'h2A;
    step(); step(); step(); step();
    total++; if (tstate !== 3'd4 || strobes !== S_ADD4) begin bad++; $display("FAIL async_reach_t4: got t=%0d s=%b want t=4 s=%b", tstate, strobes, S_ADD4); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (tstate !== 3'd0 || strobes !== S_NONE) begin bad++; $display("FAIL async_mid_instr: got t=%0d s=%b want t=0 s=0", tstate, strobes); end
    step();
    rst = 1'b1;
    #1;
    total++; if (strobes !== S_FET0) begin bad++; $display("FAIL async_release: got %b want %b", strobes, S_FET0); end
    step();
    total++; if (tstate !== 3'd1 || strobes !== S_FET1) begin bad++; $display("FAIL async_restart_t1: got t=%0d s=%b want t=1 s=%b", tstate, strobes, S_FET1); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_jump();
    test_dir();
    test_freeze();
    test_halt();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Instruction sequencer for the 8-bit computer; sits directly upstream of the program counter.
- Generates the counter's enable, load and count-direction controls, plus the MAR, memory, IR, A, B, ALU and output-register strobes.
- Steps each instruction through fetch and execute T-states.
- Decodes the opcode held in the external instruction register.

Parameters:
- DATA_W, 8, width of instruction word `ir_in`.
- OP_W, 4, opcode width; opcode is `ir_in[DATA_W-1 -: OP_W]`; operand is the remaining low bits.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `run`  input  1  sequencer enable; low freezes state.
- `ir_in`  input  DATA_W  current instruction register contents.
- `zero_flag`  input  1  ALU zero flag, registered externally.
- `carry_flag`  input  1  ALU carry flag, registered externally.
- `pc_en`  output  1  program counter count enable.
- `pc_load`  output  1  program counter parallel load; data comes from the IR operand.
- `pc_down`  output  1  program counter direction; 1 = count down.
- `addr_sel`  output  1  MAR source: 0 = PC, 1 = IR operand.
- `mar_load`  output  1  MAR load strobe.
- `mem_rd`  output  1  memory read onto the bus.
- `ir_load`  output  1  IR load strobe.
- `a_load`  output  1  A register load strobe.
- `b_load`  output  1  B register load strobe.
- `alu_sub`  output  1  ALU subtract select.
- `out_load`  output  1  output register load strobe.
- `halted`  output  1  high in the HALT state.
- `tstate`  output  3  current state encoding.

Behaviour:
- State encoding:
  - T0=0, T1=1, T2=2, T3=3, T4=4, HALT=5.
  - Codes 6 and 7 are illegal; the next edge goes to T0.
- Reset (`rst`=0, asynchronous):
  - `tstate`=T0, `pc_down`=0, `halted`=0.
  - All strobes are 0 while reset is held.
  - Reset asserted mid-instruction abandons the instruction and clears everything immediately, without waiting for a clock edge.
- `run`=0:
  - State and `pc_down` hold.
  - All strobes are forced to 0.
  - On the next edge with `run`=1, execution resumes from the held state.
- Strobes are combinational decodes of the registered state, `ir_in` and the flags. At most one T-state's strobe set is active per cycle.
- Fetch, common to all opcodes:
  - T0: `mar_load`=1, `addr_sel`=0.
  - T1: `mem_rd`=1, `ir_load`=1, `pc_en`=1.
  - T2: execute begins.
- Execute, by opcode (the instruction's last state returns to T0):
  - 0x0 NOP: T2 no strobes -> T0.
  - 0x1 LDA:
    - T2: `mar_load`, `addr_sel`=1.
    - T3: `mem_rd`, `a_load` -> T0.
  - 0x2 ADD / 0x3 SUB:
    - T2: `mar_load`, `addr_sel`=1.
    - T3: `mem_rd`, `b_load`.
    - T4: `a_load`; `alu_sub`=1 for SUB only -> T0.
  - 0x4 OUT: T2 `out_load` -> T0.
  - 0x5 JMP: T2 `pc_load` -> T0.
  - 0x6 JZ: T2 `pc_load` = `zero_flag` -> T0.
  - 0x7 JC: T2 `pc_load` = `carry_flag` -> T0.
  - 0x8 DIR: T2 sets the `pc_down` register to operand bit 0 on the edge leaving T2 -> T0. Takes effect from the next fetch's `pc_en`.
  - 0xF HLT: T2 no strobes -> HALT.
  - All other opcodes behave as NOP.
- HALT:
  - All strobes are 0 and `halted`=1.
  - HALT is left only via reset; `run` has no effect.
- `pc_en` and `pc_load` are never high in the same cycle.
- `pc_down` is a registered level, not a strobe. It is not gated by `run`.
- Flags are sampled combinationally during T2 only.
- Instruction cycle counts:
  - 3 cycles: NOP, OUT, JMP, JZ, JC, DIR, unknown opcodes.
  - 4 cycles: LDA.
  - 5 cycles: ADD, SUB.

Test Plan:
- Reset: hold `rst`=0 with `run`=1 for 3 edges -> `tstate`=0, all strobes 0, `pc_down`=0, `halted`=0. Release -> T0 strobes `mar_load`=1, `addr_sel`=0.
- Fetch plus ADD: `ir_in`=0x2A with `run`=1.
  - Sequence T0..T4, then T0.
  - `pc_en` high only in T1.
  - T3 shows `b_load`=1, `mem_rd`=1.
  - T4 shows `a_load`=1, `alu_sub`=0.
  - Same with `ir_in`=0x3A -> `alu_sub`=1 in T4.
- Conditional jump: `ir_in`=0x6C.
  - With `zero_flag`=1 -> `pc_load`=1 in T2.
  - With `zero_flag`=0 -> `pc_load`=0.
  - Both cases return to T0 after 3 cycles.
- Direction: `ir_in`=0x81 -> `pc_down`=1 after the T2 edge, and it persists across following instructions. Then `ir_in`=0x80 -> `pc_down`=0.
- Freeze and halt:
  - Drop `run` in T3 of LDA for 4 cycles -> `tstate` stays 3, strobes 0. Raise `run` -> `a_load` fires.
  - `ir_in`=0xF0 -> HALT (`tstate`=5, `halted`=1), held for 10 cycles despite `run`=1.
- Async reset mid-operation: assert `rst`=0 between edges during T4 of ADD -> `tstate`=0 and strobes 0 before the next rising edge.
